// File: rtl/wei_fetch_buf.sv
// +----------------------------------------------------------------------------+
// | wei_fetch_buf: per-PEB weight fetch engine and flag/weight stream buffer    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module wei_fetch_buf #(
   parameter int WEI_WR_WIDTH    = 128,
   parameter int FLGWEI_WR_WIDTH = 64,
   parameter int IDWEI_WIDTH     = 5,
   parameter int INSTR_WIDTH     = 8,
   parameter int PEB_ID          = 0,
   parameter int DEPTH           = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [3:0]                 cfg_num_wei,
   input  logic                       start,
   input  logic                       stop,
   output logic                       busy,
   output logic                       err,
   input  logic                       GBWEI_instr_rdy,
   output logic                       WEIGB_instr_val,
   output logic [INSTR_WIDTH-1:0]     WEIGB_instr_data,
   input  logic                       GBFLGWEI_val,
   output logic                       FLGWEIGB_rdy,
   input  logic [FLGWEI_WR_WIDTH-1:0] GBFLGWEI_data,
   input  logic                       GBWEI_val,
   output logic                       WEIGB_rdy,
   input  logic [IDWEI_WIDTH-1:0]     GBWEI_idwei,
   input  logic [WEI_WR_WIDTH-1:0]    GBWEI_data,
   input  logic                       PE_wei_rdy,
   output logic                       WEIPE_val,
   output logic [WEI_WR_WIDTH-1:0]    WEIPE_data,
   output logic [FLGWEI_WR_WIDTH-1:0] WEIPE_flg,
   output logic                       WEIPE_last
);

   localparam int         AW       = $clog2(DEPTH);
   localparam int         CW       = $clog2(DEPTH + 1);
   localparam logic [3:0] c_peb_id = 4'(PEB_ID);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RECV = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [3:0] r_n_code;
   logic [4:0] w_n_val;
   logic [4:0] r_rcv_cnt;
   logic [4:0] w_rcv_nxt;
   logic       r_flag_got;
   logic       w_flag_nxt;
   logic       r_stop_pend;
   logic       r_err;

   logic [WEI_WR_WIDTH-1:0] r_wmem [DEPTH];
   logic [AW-1:0]           r_wwr;
   logic [AW-1:0]           r_wrd;
   logic [CW-1:0]           r_wcnt;
   logic [CW-1:0]           w_wfree;

   // Each flag entry carries its group's N code so the output side knows where "last" falls
   logic [FLGWEI_WR_WIDTH-1:0] r_fmem  [2];
   logic [3:0]                 r_fcode [2];
   logic                       r_fwr;
   logic                       r_frd;
   logic [1:0]                 r_fcnt;
   logic [3:0]                 r_out_cnt;

   logic w_instr_ok;
   logic w_instr_xfer;
   logic w_flg_push;
   logic w_wei_push;
   logic w_done;
   logic w_seq_err;
   logic w_out_val;
   logic w_pop;
   logic w_fpop;

   assign w_n_val  = (r_n_code == 4'd0) ? 5'd16 : {1'b0, r_n_code};
   assign w_wfree  = CW'(DEPTH) - r_wcnt;

   // Only one fetch is in flight, so free space in REQ already accounts for every prior group
   assign w_instr_ok   = (w_wfree >= CW'(w_n_val)) && (r_fcnt != 2'd2);
   assign w_instr_xfer = WEIGB_instr_val && GBWEI_instr_rdy;

   assign w_flg_push = GBFLGWEI_val && FLGWEIGB_rdy;
   assign w_wei_push = GBWEI_val && WEIGB_rdy;
   assign w_rcv_nxt  = r_rcv_cnt + 5'(w_wei_push);
   assign w_flag_nxt = r_flag_got | w_flg_push;
   assign w_done     = (r_state == S_RECV) && w_flag_nxt && (w_rcv_nxt == w_n_val);
   assign w_seq_err  = w_wei_push && (GBWEI_idwei != IDWEI_WIDTH'(r_rcv_cnt));

   assign w_out_val = (r_wcnt != '0) && (r_fcnt != 2'd0);
   assign w_pop     = w_out_val && PE_wei_rdy;
   assign w_fpop    = w_pop && WEIPE_last;

   assign busy             = (r_state != S_IDLE);
   assign err              = r_err;
   assign WEIGB_instr_val  = (r_state == S_REQ) && w_instr_ok;
   assign WEIGB_instr_data = WEIGB_instr_val ? INSTR_WIDTH'({r_n_code, c_peb_id}) : '0;
   assign FLGWEIGB_rdy     = (r_state == S_RECV) && !r_flag_got;
   assign WEIGB_rdy        = (r_state == S_RECV) && (r_rcv_cnt < w_n_val);
   assign WEIPE_val        = w_out_val;
   assign WEIPE_data       = w_out_val ? r_wmem[r_wrd] : '0;
   assign WEIPE_flg        = (r_fcnt != 2'd0) ? r_fmem[r_frd] : '0;
   assign WEIPE_last       = w_out_val && (r_out_cnt == (r_fcode[r_frd] - 4'd1));

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (start) w_state_nxt = S_REQ;
         S_REQ: begin
            if (w_instr_xfer)  w_state_nxt = S_RECV;
            else if (stop)     w_state_nxt = S_IDLE;
         end
         S_RECV: begin
            if (w_done) w_state_nxt = (r_stop_pend || stop) ? S_IDLE : S_REQ;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_n_code    <= 4'd0;
         r_rcv_cnt   <= 5'd0;
         r_flag_got  <= 1'b0;
         r_stop_pend <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_IDLE && start) r_n_code <= cfg_num_wei;
         if (w_instr_xfer) begin
            r_rcv_cnt  <= 5'd0;
            r_flag_got <= 1'b0;
         end else if (r_state == S_RECV) begin
            r_rcv_cnt  <= w_rcv_nxt;
            r_flag_got <= w_flag_nxt;
         end
         if (w_state_nxt == S_IDLE)
            r_stop_pend <= 1'b0;
         else if (stop && (r_state == S_RECV || w_instr_xfer))
            r_stop_pend <= 1'b1;
         if (w_seq_err) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wei_push) r_wmem[r_wwr] <= GBWEI_data;
      if (w_flg_push) begin
         r_fmem[r_fwr]  <= GBFLGWEI_data;
         r_fcode[r_fwr] <= r_n_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wwr     <= '0;
         r_wrd     <= '0;
         r_wcnt    <= '0;
         r_fwr     <= 1'b0;
         r_frd     <= 1'b0;
         r_fcnt    <= 2'd0;
         r_out_cnt <= 4'd0;
      end else begin
         if (w_wei_push) r_wwr <= r_wwr + AW'(1);
         if (w_pop)      r_wrd <= r_wrd + AW'(1);
         case ({w_wei_push, w_pop})
            2'b10:   r_wcnt <= r_wcnt + CW'(1);
            2'b01:   r_wcnt <= r_wcnt - CW'(1);
            default: r_wcnt <= r_wcnt;
         endcase
         if (w_flg_push) r_fwr <= ~r_fwr;
         if (w_fpop)     r_frd <= ~r_frd;
         case ({w_flg_push, w_fpop})
            2'b10:   r_fcnt <= r_fcnt + 2'd1;
            2'b01:   r_fcnt <= r_fcnt - 2'd1;
            default: r_fcnt <= r_fcnt;
         endcase
         if (w_fpop)     r_out_cnt <= 4'd0;
         else if (w_pop) r_out_cnt <= r_out_cnt + 4'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wei_fetch_buf.sv
// +----------------------------------------------------------------------------+
// | tb_wei_fetch_buf: self-checking bench with global-buffer model and scoreboard |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_wei_fetch_buf;

   localparam int WW = 128, FW = 64, IW = 5, INW = 8, PEB = 5, DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b1, start = 1'b0, stop = 1'b0;
   logic [3:0]     cfg_num_wei = 4'd0;
   logic           busy, err;
   logic           GBWEI_instr_rdy = 1'b0, WEIGB_instr_val;
   logic [INW-1:0] WEIGB_instr_data;
   logic           GBFLGWEI_val = 1'b0, FLGWEIGB_rdy;
   logic [FW-1:0]  GBFLGWEI_data = '0;
   logic           GBWEI_val = 1'b0, WEIGB_rdy;
   logic [IW-1:0]  GBWEI_idwei = '0;
   logic [WW-1:0]  GBWEI_data = '0;
   logic           PE_wei_rdy = 1'b0, WEIPE_val, WEIPE_last;
   logic [WW-1:0]  WEIPE_data;
   logic [FW-1:0]  WEIPE_flg;

   wei_fetch_buf #(.WEI_WR_WIDTH(WW), .FLGWEI_WR_WIDTH(FW), .IDWEI_WIDTH(IW),
                   .INSTR_WIDTH(INW), .PEB_ID(PEB), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .cfg_num_wei(cfg_num_wei), .start(start), .stop(stop),
      .busy(busy), .err(err), .GBWEI_instr_rdy(GBWEI_instr_rdy),
      .WEIGB_instr_val(WEIGB_instr_val), .WEIGB_instr_data(WEIGB_instr_data),
      .GBFLGWEI_val(GBFLGWEI_val), .FLGWEIGB_rdy(FLGWEIGB_rdy), .GBFLGWEI_data(GBFLGWEI_data),
      .GBWEI_val(GBWEI_val), .WEIGB_rdy(WEIGB_rdy), .GBWEI_idwei(GBWEI_idwei),
      .GBWEI_data(GBWEI_data), .PE_wei_rdy(PE_wei_rdy), .WEIPE_val(WEIPE_val),
      .WEIPE_data(WEIPE_data), .WEIPE_flg(WEIPE_flg), .WEIPE_last(WEIPE_last));

   int n_checks = 0, n_pass = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   typedef struct packed {
      logic [WW-1:0] d;
      logic [FW-1:0] f;
      logic          l;
   } beat_t;

   beat_t exp_q[$];
   beat_t e_beat;
   int    held = 0;
   bit    running = 0;

   function automatic logic [WW-1:0] wdata(input logic [FW-1:0] f, input int i);
      return {f, 64'(i)};
   endfunction

   // Expected PE stream: each group's words in order, its own flag, last on word N-1
   task automatic push_group(input int n, input logic [FW-1:0] f);
      for (int i = 0; i < n; i++) exp_q.push_back('{wdata(f, i), f, (i == n - 1)});
   endtask

   always @(negedge clk) begin
      if (!rst && WEIPE_val && PE_wei_rdy) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got data %0h, required no output", WEIPE_data);
         end else begin
            e_beat = exp_q.pop_front();
            chk("pe_beat", {WEIPE_data, WEIPE_flg, WEIPE_last}, e_beat);
            held--;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] all_outs();
      return {busy, err, WEIGB_instr_val, WEIGB_instr_data, FLGWEIGB_rdy, WEIGB_rdy,
              WEIPE_val, WEIPE_data, WEIPE_flg, WEIPE_last};
   endfunction

   task automatic do_reset(input string name);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      held = 0;
      #1;
      chk(name, all_outs(), '0);
   endtask

   task automatic pulse_start(input logic [3:0] code);
      cfg_num_wei = code;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic take_instr(input logic [7:0] exp, input int n);
      int t = 0;
      GBWEI_instr_rdy = 1'b1;
      while (t < 200) begin
         @(negedge clk);
         if (WEIGB_instr_val) break;
         t++;
      end
      chk("instr_wait", (t < 200), 1);
      if (t < 200) begin
         chk("instr_data", WEIGB_instr_data, exp);
         chk("instr_space", (held + n <= DEPTH), 1);
      end
      @(posedge clk);
      #1;
      GBWEI_instr_rdy = 1'b0;
   endtask

   task automatic watch_instr(input int cycles, output bit seen, output logic [7:0] data);
      seen = 0;
      data = '0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (WEIGB_instr_val && !seen) begin
            seen = 1;
            data = WEIGB_instr_data;
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Global-buffer return model: valid/data hold until taken, optional random gaps
   task automatic gb_send(input int n, input logic [FW-1:0] f, input int flag_after,
                          input int bad_at, input bit gaps, input bit chk_wait);
      int wi = 0, t = 0;
      bit fs = 0, viol = 0, instr_seen = 0, acc_w, acc_f;
      while ((wi < n || !fs) && t < 400) begin
         if (!GBWEI_val && wi < n && (!gaps || $urandom_range(0, 2) != 0)) begin
            GBWEI_val   = 1'b1;
            GBWEI_idwei = IW'((wi == bad_at) ? wi + 1 : wi);
            GBWEI_data  = wdata(f, wi);
         end
         if (!GBFLGWEI_val && !fs && wi >= flag_after && (!gaps || $urandom_range(0, 2) != 0)) begin
            GBFLGWEI_val  = 1'b1;
            GBFLGWEI_data = f;
         end
         @(negedge clk);
         if (chk_wait && !fs && WEIPE_val) viol = 1;
         if (WEIGB_instr_val) instr_seen = 1;
         acc_w = GBWEI_val && WEIGB_rdy;
         acc_f = GBFLGWEI_val && FLGWEIGB_rdy;
         if (acc_w) begin
            wi++;
            held++;
         end
         if (acc_f) fs = 1;
         @(posedge clk);
         #1;
         if (acc_w) GBWEI_val = 1'b0;
         if (acc_f) GBFLGWEI_val = 1'b0;
         t++;
      end
      GBWEI_val    = 1'b0;
      GBFLGWEI_val = 1'b0;
      chk("gb_send_done", (t < 400), 1);
      chk("one_outstanding", instr_seen, 0);
      if (chk_wait) chk("val_waits_flag", viol, 0);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         step();
         t++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   typedef struct {
      logic [3:0]    cfg;
      logic [FW-1:0] flg;
      int            fa;
      int            bad;
      logic [7:0]    ins;
      logic          e;
   } vec_t;

   vec_t tbl[5];

   // One group with a stop during RECV: it must complete, then the engine idles
   task automatic run_group(input vec_t v);
      int  n;
      bit  seen;
      logic [7:0] d;
      n = (v.cfg == 4'd0) ? 16 : int'(v.cfg);
      pulse_start(v.cfg);
      push_group(n, v.flg);
      take_instr(v.ins, n);
      pulse_stop();
      gb_send(n, v.flg, v.fa, v.bad, 0, 1);
      drain("grp_drain");
      watch_instr(4, seen, d);
      chk("grp_no_instr_after_stop", seen, 0);
      chk("grp_idle", busy, 0);
      chk("grp_err", err, v.e);
   endtask

   initial begin
      bit         seen;
      logic [7:0] d;
      logic [3:0] code;
      int         n, t;
      logic [FW-1:0] f;

      tbl[0] = '{4'd3, 64'h0123_4567_89AB_CDEF, 0, -1, 8'h35, 1'b0};
      tbl[1] = '{4'd4, 64'hFEDC_BA98_7654_3210, 4, -1, 8'h45, 1'b0};
      tbl[2] = '{4'd5, 64'h1111_2222_3333_4444, 2, -1, 8'h55, 1'b0};
      tbl[3] = '{4'd1, 64'hDEAD_BEEF_CAFE_F00D, 1, -1, 8'h15, 1'b0};
      tbl[4] = '{4'd2, 64'h5A5A_A5A5_0F0F_F0F0, 0,  1, 8'h25, 1'b1};

      step();
      do_reset("reset_outputs");
      PE_wei_rdy = 1'b1;
      for (int i = 0; i < 5; i++) run_group(tbl[i]);
      step();
      chk("err_sticky", err, 1);
      do_reset("reset_clears_err");

      // Backpressure with N=16: a full FIFO blocks the next request until fully drained
      PE_wei_rdy = 1'b0;
      f = 64'hAAAA_BBBB_CCCC_DDDD;
      pulse_start(4'd0);
      push_group(16, f);
      take_instr(8'h05, 16);
      gb_send(16, f, 0, -1, 0, 0);
      chk("bp_wei_rdy_low", WEIGB_rdy, 0);
      watch_instr(5, seen, d);
      chk("bp_no_instr_full", seen, 0);
      PE_wei_rdy = 1'b1;
      step();
      PE_wei_rdy = 1'b0;
      watch_instr(5, seen, d);
      chk("bp_no_instr_1pop", seen, 0);
      PE_wei_rdy = 1'b1;
      t = 0;
      while (exp_q.size() > 1 && t < 50) begin
         step();
         t++;
      end
      PE_wei_rdy = 1'b0;
      watch_instr(5, seen, d);
      chk("bp_no_instr_15pop", seen, 0);
      PE_wei_rdy = 1'b1;
      drain("bp_drain");
      watch_instr(5, seen, d);
      chk("bp_instr_after_drain", {seen, d}, {1'b1, 8'h05});
      pulse_stop();
      step();
      chk("bp_stop_idle", {busy, WEIGB_instr_val}, 2'b00);

      // Reset in the middle of RECV discards the partial group
      PE_wei_rdy = 1'b0;
      pulse_start(4'd4);
      take_instr(8'h45, 4);
      gb_send(2, 64'h7777_8888_9999_AAAA, 0, -1, 0, 0);
      rst = 1'b1;
      step();
      chk("rst_mid_recv", all_outs(), '0);
      rst = 1'b0;
      exp_q.delete();
      held = 0;
      PE_wei_rdy = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (WEIPE_val) seen = 1;
         step();
      end
      chk("no_partial_output", seen, 0);
      run_group('{4'd3, 64'h0BAD_F00D_0BAD_F00D, 1, -1, 8'h35, 1'b0});

      // Randomized runs: several back-to-back groups per start, random PE backpressure
      for (int r = 0; r < 3; r++) begin
         do_reset("rand_reset");
         running = 1;
         fork
            while (running) begin
               PE_wei_rdy = ($urandom_range(0, 3) != 0);
               step();
            end
         join_none
         code = 4'($urandom_range(0, 15));
         n = (code == 4'd0) ? 16 : int'(code);
         pulse_start(code);
         for (int g = 0; g < 4; g++) begin
            f = {$urandom, $urandom};
            push_group(n, f);
            take_instr({code, 4'(PEB)}, n);
            gb_send(n, f, int'($urandom_range(0, n)), -1, 1, 0);
         end
         pulse_stop();
         running = 0;
         step();
         step();
         PE_wei_rdy = 1'b1;
         drain("rand_drain");
         chk("rand_idle_noerr", {busy, err}, 2'b00);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
